// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and coordinate/sync types.
// Used by the timing generator and by the renderer that consumes its outputs.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    // Both syncs are active-low, so the idle tuple is (1,1,0).
    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};

    function automatic logic in_window(coord_t v, coord_t lo, coord_t len);
        return (v >= lo) && ({1'b0, v} < ({1'b0, lo} + {1'b0, len}));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle driven by vga_timing_gen (master) and read by the renderer (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t      DrawX;
    coord_t      DrawY;
    logic        blank;
    logic        blank_d;
    logic        hs;
    logic        vs;
    logic        frame_start;
    logic        vblank_start;
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, blank_d, hs, vs,
               frame_start, vblank_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, blank_d, hs, vs,
               frame_start, vblank_start, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Parametric width/depth shift register with a synchronous reset value.
// DEPTH = 0 is a straight pass-through of an already-registered input.
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_reset;
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Advance one stage per clock; reset flushes every stage to the idle value.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, sync/blank, frame strobes and frame counter.
// Strobes are decoded from next-state counters so they line up with DrawX/DrawY.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIPE_DELAY  = 2,
    parameter int P_H_VISIBLE = H_VISIBLE,
    parameter int P_H_FP      = H_FP,
    parameter int P_H_SYNC    = H_SYNC,
    parameter int P_H_BP      = H_BP,
    parameter int P_V_VISIBLE = V_VISIBLE,
    parameter int P_V_FP      = V_FP,
    parameter int P_V_SYNC    = V_SYNC,
    parameter int P_V_BP      = V_BP
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int     HT         = P_H_VISIBLE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int     VT         = P_V_VISIBLE + P_V_FP + P_V_SYNC + P_V_BP;
    localparam coord_t H_LAST     = coord_t'(HT - 1);
    localparam coord_t V_LAST     = coord_t'(VT - 1);
    localparam coord_t H_VIS_C    = coord_t'(P_H_VISIBLE);
    localparam coord_t V_VIS_C    = coord_t'(P_V_VISIBLE);
    localparam coord_t H_SYNC_LO  = coord_t'(P_H_VISIBLE + P_H_FP);
    localparam coord_t H_SYNC_LEN = coord_t'(P_H_SYNC);
    localparam coord_t V_SYNC_LO  = coord_t'(P_V_VISIBLE + P_V_FP);
    localparam coord_t V_SYNC_LEN = coord_t'(P_V_SYNC);

    coord_t      r_x;
    coord_t      r_y;
    sync_t       r_sync;
    logic        r_frame_start;
    logic        r_vblank_start;
    logic [15:0] r_frame_count;

    coord_t      w_x_next;
    coord_t      w_y_next;
    logic        w_x_wrap;
    logic        w_y_wrap;
    sync_t       w_sync_next;
    sync_t       w_sync_delayed;

    assign w_x_wrap = (r_x == H_LAST);
    assign w_y_wrap = (r_y == V_LAST);
    assign w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;
    assign w_y_next = !w_x_wrap ? r_y : (w_y_wrap ? 10'd0 : r_y + 10'd1);

    assign w_sync_next.hsync = !in_window(w_x_next, H_SYNC_LO, H_SYNC_LEN);
    assign w_sync_next.vsync = !in_window(w_y_next, V_SYNC_LO, V_SYNC_LEN);
    assign w_sync_next.blank = (w_x_next < H_VIS_C) && (w_y_next < V_VIS_C);

    // Counters, undelayed sync/blank and strobes; reset parks at the last pixel of a frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_x            <= H_LAST;
            r_y            <= V_LAST;
            r_sync         <= SYNC_IDLE;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_frame_count  <= 16'd0;
        end else begin
            r_x            <= w_x_next;
            r_y            <= w_y_next;
            r_sync         <= w_sync_next;
            r_frame_start  <= (w_x_next == 10'd0) && (w_y_next == 10'd0);
            r_vblank_start <= (w_x_next == 10'd0) && (w_y_next == V_VIS_C);
            if (w_x_wrap && w_y_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end else begin
                r_frame_count <= r_frame_count;
            end
        end
    end

    sync_delay #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .i_clk   (vga_clk),
        .i_reset (reset),
        .i_d     (r_sync),
        .o_q     (w_sync_delayed)
    );

    assign vga.DrawX        = r_x;
    assign vga.DrawY        = r_y;
    assign vga.blank        = r_sync.blank;
    assign vga.blank_d      = w_sync_delayed.blank;
    assign vga.hs           = w_sync_delayed.hsync;
    assign vga.vs           = w_sync_delayed.vsync;
    assign vga.frame_start  = r_frame_start;
    assign vga.vblank_start = r_vblank_start;
    assign vga.frame_count  = r_frame_count;

endmodule
